// File: rtl/proc_pkg.sv
// Shared processor definitions: opcode field layout, legal opcode range,
// fetch-stage state encoding and the opcode constants used by decode/control.
package proc_pkg;

  localparam int OPCODE_W = 4;
  localparam int NUM_OPS  = 12;
  localparam int INSTR_W  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    ISSUE  = 3'd3,
    EXEC   = 3'd4,
    HALT   = 3'd5
  } fetch_state_e;

  // Opcodes 12..15 are unassigned and trap as illegal.
  localparam logic [OPCODE_W-1:0] OP_NOP   = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_LOAD  = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_STORE = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_ADD   = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_SUB   = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_AND   = 4'd5;
  localparam logic [OPCODE_W-1:0] OP_OR    = 4'd6;
  localparam logic [OPCODE_W-1:0] OP_XOR   = 4'd7;
  localparam logic [OPCODE_W-1:0] OP_SHL   = 4'd8;
  localparam logic [OPCODE_W-1:0] OP_SHR   = 4'd9;
  localparam logic [OPCODE_W-1:0] OP_JMP   = 4'd10;
  localparam logic [OPCODE_W-1:0] OP_JZ    = 4'd11;

  function automatic int opcode_msb(input int instr_w);
    return instr_w - 1;
  endfunction

  function automatic int operand_msb(input int instr_w);
    return instr_w - OPCODE_W - 1;
  endfunction

  function automatic logic op_is_legal(input logic [OPCODE_W-1:0] op, input int num_ops);
    return int'(op) < num_ops;
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Multi-cycle fetch stage: fetches over req/ack, latches the IR, sequences the
// decoder EN_OP/EN_OUT strobes and owns the program counter.
module instr_fetch_unit #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16,
  parameter int NUM_OPS = proc_pkg::NUM_OPS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  output logic [PC_W-1:0]            mem_addr,
  output logic                       mem_req,
  input  logic                       mem_ack,
  input  logic [INSTR_W-1:0]         mem_rdata,
  input  logic                       pc_load,
  input  logic [PC_W-1:0]            pc_load_val,
  input  logic                       instr_done,
  output logic [proc_pkg::OPCODE_W-1:0] opcode,
  output logic [INSTR_W-5:0]         operand,
  output logic                       en_op,
  output logic                       en_out,
  output logic [PC_W-1:0]            pc,
  output logic                       busy,
  output logic                       illegal,
  output proc_pkg::fetch_state_e     fsm_state
);
  import proc_pkg::*;

  // Memory handshake: mem_req is a level held from entry into FETCH until the
  // cycle mem_ack is sampled high; mem_rdata is captured on that same edge and
  // mem_ack seen in any other state is ignored.

  fetch_state_e           state;
  logic [INSTR_W-1:0]     ir;

  assign opcode    = ir[opcode_msb(INSTR_W) -: OPCODE_W];
  assign operand   = ir[operand_msb(INSTR_W):0];
  assign mem_addr  = pc;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= '0;
      ir      <= '0;
      mem_req <= 1'b0;
      en_op   <= 1'b0;
      en_out  <= 1'b0;
      illegal <= 1'b0;
      busy    <= 1'b0;
    end else begin
      en_op  <= 1'b0;
      en_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (run) begin
            state   <= FETCH;
            mem_req <= 1'b1;
            busy    <= 1'b1;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            ir      <= mem_rdata;
            pc      <= pc + PC_W'(1);
            mem_req <= 1'b0;
            state   <= DECODE;
          end
        end
        DECODE: begin
          // Illegal opcodes trap without ever strobing the decoder.
          if (!op_is_legal(opcode, NUM_OPS)) begin
            illegal <= 1'b1;
            busy    <= 1'b0;
            state   <= HALT;
          end else begin
            en_op <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          en_out <= 1'b1;
          state  <= EXEC;
        end
        EXEC: begin
          // A branch target seen on the completing cycle still lands, so the
          // following fetch uses it.
          if (pc_load) pc <= pc_load_val;
          if (instr_done) begin
            if (run) begin
              state   <= FETCH;
              mem_req <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: each task drives one scenario and checks
// outputs half a cycle after the active edge against hand-computed values.
module tb_instr_fetch_unit;
  import proc_pkg::*;

  logic              clk;
  logic              rst;
  logic              run;
  logic [7:0]        mem_addr;
  logic              mem_req;
  logic              mem_ack;
  logic [15:0]       mem_rdata;
  logic              pc_load;
  logic [7:0]        pc_load_val;
  logic              instr_done;
  logic [3:0]        opcode;
  logic [11:0]       operand;
  logic              en_op;
  logic              en_out;
  logic [7:0]        pc;
  logic              busy;
  logic              illegal;
  fetch_state_e      fsm_state;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(.PC_W(8), .INSTR_W(16), .NUM_OPS(12)) dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .pc_load(pc_load), .pc_load_val(pc_load_val), .instr_done(instr_done),
    .opcode(opcode), .operand(operand), .en_op(en_op), .en_out(en_out),
    .pc(pc), .busy(busy), .illegal(illegal), .fsm_state(fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs are driven and outputs sampled at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    pc_load = 1'b0; pc_load_val = '0; instr_done = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %h exp 00", pc); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", mem_req); end
    checks++; if (en_op !== 1'b0 || en_out !== 1'b0) begin errors++; $display("FAIL reset_strobes got %b%b exp 00", en_op, en_out); end
    checks++; if (busy !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL reset_flags got busy %b illegal %b exp 0 0", busy, illegal); end
    checks++; if (opcode !== 4'h0 || operand !== 12'h000) begin errors++; $display("FAIL reset_ir got %h %h exp 0 000", opcode, operand); end
    checks++; if (fsm_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", fsm_state, IDLE); end
  endtask

  task automatic test_basic_fetch();
    run = 1'b1;
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin errors++; $display("FAIL basic_req got req %b addr %h exp 1 00", mem_req, mem_addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy); end
    mem_ack = 1'b1; mem_rdata = 16'h3ABC;
    step();
    mem_ack = 1'b0;
    checks++; if (opcode !== 4'h3 || operand !== 12'hABC) begin errors++; $display("FAIL basic_ir got %h %h exp 3 abc", opcode, operand); end
    checks++; if (pc !== 8'h01) begin errors++; $display("FAIL basic_pc got %h exp 01", pc); end
    checks++; if (mem_req !== 1'b0 || en_op !== 1'b0) begin errors++; $display("FAIL basic_decode got req %b en_op %b exp 0 0", mem_req, en_op); end
    step();
    checks++; if (en_op !== 1'b1 || en_out !== 1'b0) begin errors++; $display("FAIL basic_en_op got %b%b exp 10", en_op, en_out); end
    step();
    checks++; if (en_op !== 1'b0 || en_out !== 1'b1) begin errors++; $display("FAIL basic_en_out got %b%b exp 01", en_op, en_out); end
    checks++; if (fsm_state !== EXEC) begin errors++; $display("FAIL basic_exec got %0d exp %0d", fsm_state, EXEC); end
    step();
    checks++; if (en_out !== 1'b0 || fsm_state !== EXEC) begin errors++; $display("FAIL basic_hold got en_out %b state %0d exp 0 %0d", en_out, fsm_state, EXEC); end
    run = 1'b0; instr_done = 1'b1;
    step();
    instr_done = 1'b0;
    checks++; if (fsm_state !== IDLE || busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL basic_idle got state %0d busy %b req %b exp %0d 0 0", fsm_state, busy, mem_req, IDLE); end
  endtask

  task automatic test_wait_ack();
    run = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h01) begin errors++; $display("FAIL wait_req cyc %0d got req %b addr %h exp 1 01", i, mem_req, mem_addr); end
      checks++; if (en_op !== 1'b0 || en_out !== 1'b0) begin errors++; $display("FAIL wait_strobe cyc %0d got %b%b exp 00", i, en_op, en_out); end
      if (i < 5) step();
    end
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    step();
    // Stray ack and branch request in DECODE must both be ignored.
    mem_ack = 1'b1; mem_rdata = 16'hFFFF; pc_load = 1'b1; pc_load_val = 8'h77;
    checks++; if (opcode !== 4'h1 || operand !== 12'h234 || pc !== 8'h02) begin errors++; $display("FAIL wait_ir got %h %h pc %h exp 1 234 02", opcode, operand, pc); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL wait_req_drop got %b exp 0", mem_req); end
    step();
    mem_ack = 1'b0; pc_load = 1'b0;
    checks++; if (opcode !== 4'h1 || operand !== 12'h234) begin errors++; $display("FAIL wait_single_load got %h %h exp 1 234", opcode, operand); end
    checks++; if (pc !== 8'h02 || en_op !== 1'b1) begin errors++; $display("FAIL wait_no_load got pc %h en_op %b exp 02 1", pc, en_op); end
    step();
    checks++; if (en_out !== 1'b1 || fsm_state !== EXEC) begin errors++; $display("FAIL wait_exec got en_out %b state %0d exp 1 %0d", en_out, fsm_state, EXEC); end
  endtask

  task automatic test_pc_load();
    pc_load = 1'b1; pc_load_val = 8'h20;
    step();
    pc_load = 1'b0;
    checks++; if (pc !== 8'h20 || fsm_state !== EXEC) begin errors++; $display("FAIL load_early got pc %h state %0d exp 20 %0d", pc, fsm_state, EXEC); end
    pc_load = 1'b1; pc_load_val = 8'h40; instr_done = 1'b1;
    step();
    pc_load = 1'b0; instr_done = 1'b0;
    checks++; if (fsm_state !== FETCH || mem_req !== 1'b1 || mem_addr !== 8'h40) begin errors++; $display("FAIL load_fetch got state %0d req %b addr %h exp %0d 1 40", fsm_state, mem_req, mem_addr, FETCH); end
    mem_ack = 1'b1; mem_rdata = 16'h5001;
    step();
    mem_ack = 1'b0;
    checks++; if (pc !== 8'h41 || opcode !== 4'h5 || operand !== 12'h001) begin errors++; $display("FAIL load_after got pc %h op %h opd %h exp 41 5 001", pc, opcode, operand); end
    step(); step();
    checks++; if (fsm_state !== EXEC) begin errors++; $display("FAIL load_exec got %0d exp %0d", fsm_state, EXEC); end
  endtask

  task automatic test_wrap();
    pc_load = 1'b1; pc_load_val = 8'hFF; instr_done = 1'b1;
    step();
    pc_load = 1'b0; instr_done = 1'b0;
    checks++; if (mem_addr !== 8'hFF || mem_req !== 1'b1) begin errors++; $display("FAIL wrap_addr got %h req %b exp ff 1", mem_addr, mem_req); end
    mem_ack = 1'b1; mem_rdata = 16'h2000;
    step();
    mem_ack = 1'b0;
    checks++; if (pc !== 8'h00 || opcode !== 4'h2) begin errors++; $display("FAIL wrap_pc got pc %h op %h exp 00 2", pc, opcode); end
    step(); step();
    run = 1'b0; instr_done = 1'b1;
    step();
    instr_done = 1'b0;
    checks++; if (fsm_state !== IDLE || pc !== 8'h00) begin errors++; $display("FAIL wrap_idle got state %0d pc %h exp %0d 00", fsm_state, pc, IDLE); end
  endtask

  task automatic test_illegal();
    run = 1'b1;
    step();
    checks++; if (mem_addr !== 8'h00 || mem_req !== 1'b1) begin errors++; $display("FAIL ill_req got %h %b exp 00 1", mem_addr, mem_req); end
    mem_ack = 1'b1; mem_rdata = 16'hC000;
    step();
    mem_ack = 1'b0;
    checks++; if (opcode !== 4'hC || en_op !== 1'b0) begin errors++; $display("FAIL ill_decode got op %h en_op %b exp c 0", opcode, en_op); end
    step();
    checks++; if (fsm_state !== HALT || illegal !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ill_halt got state %0d illegal %b busy %b exp %0d 1 0", fsm_state, illegal, busy, HALT); end
    checks++; if (en_op !== 1'b0 || en_out !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL ill_quiet got %b%b req %b exp 00 0", en_op, en_out, mem_req); end
    for (int i = 0; i < 4; i++) begin
      mem_ack = i[0]; instr_done = 1'b1; pc_load = 1'b1; pc_load_val = 8'h55;
      step();
      checks++; if (fsm_state !== HALT || mem_req !== 1'b0 || en_op !== 1'b0 || en_out !== 1'b0) begin errors++; $display("FAIL ill_stay cyc %0d got state %0d req %b strobes %b%b exp %0d 0 00", i, fsm_state, mem_req, en_op, en_out, HALT); end
      checks++; if (illegal !== 1'b1 || pc !== 8'h01) begin errors++; $display("FAIL ill_sticky cyc %0d got illegal %b pc %h exp 1 01", i, illegal, pc); end
    end
    mem_ack = 1'b0; instr_done = 1'b0; pc_load = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    rst = 1'b1; run = 1'b0;
    step();
    rst = 1'b0;
    checks++; if (illegal !== 1'b0 || fsm_state !== IDLE) begin errors++; $display("FAIL rst_halt got illegal %b state %0d exp 0 %0d", illegal, fsm_state, IDLE); end
    run = 1'b1;
    step();
    mem_ack = 1'b1; mem_rdata = 16'h4567;
    step();
    mem_ack = 1'b0;
    step(); step();
    instr_done = 1'b1;
    step();
    instr_done = 1'b0;
    checks++; if (fsm_state !== FETCH || mem_req !== 1'b1 || mem_addr !== 8'h01 || opcode !== 4'h4) begin errors++; $display("FAIL rst_pre got state %0d req %b addr %h op %h exp %0d 1 01 4", fsm_state, mem_req, mem_addr, opcode, FETCH); end
    // Reset coincides with an ack, then the ack lingers one more cycle.
    rst = 1'b1; run = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h9999;
    step();
    rst = 1'b0;
    checks++; if (pc !== 8'h00 || opcode !== 4'h0 || operand !== 12'h000) begin errors++; $display("FAIL rst_regs got pc %h op %h opd %h exp 00 0 000", pc, opcode, operand); end
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || fsm_state !== IDLE) begin errors++; $display("FAIL rst_ctrl got req %b busy %b state %0d exp 0 0 %0d", mem_req, busy, fsm_state, IDLE); end
    step();
    mem_ack = 1'b0;
    checks++; if (opcode !== 4'h0 || operand !== 12'h000 || pc !== 8'h00) begin errors++; $display("FAIL rst_late_ack got op %h opd %h pc %h exp 0 000 00", opcode, operand, pc); end
    step(); step();
    checks++; if (fsm_state !== IDLE || mem_req !== 1'b0 || en_op !== 1'b0 || en_out !== 1'b0) begin errors++; $display("FAIL rst_idle got state %0d req %b strobes %b%b exp %0d 0 00", fsm_state, mem_req, en_op, en_out, IDLE); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_wait_ack();
    test_pc_load();
    test_wrap();
    test_illegal();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Bounds the whole run in case stimulus ever stops advancing.
  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
